// File: rtl/ps2_scan_rx_if.sv
// rtl/ps2_scan_rx_if.sv - key event bus from the PS/2 receiver to the matrix stage
interface ps2_scan_rx_if;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       frame_err;
  logic       busy;

  modport master (
    output key_valid, key_code, key_ext, key_release, frame_err, busy
  );

  modport slave (
    input key_valid, key_code, key_ext, key_release, frame_err, busy
  );
endinterface

// File: rtl/ps2_scan_rx.sv
// rtl/ps2_scan_rx.sv - PS/2 device-to-host frame receiver folding E0/F0 prefixes into key events
module ps2_scan_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ps2_clk,
  input  logic          ps2_dat,
  ps2_scan_rx_if.master key
);

  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_next;
  logic [1:0]    clk_sync, dat_sync;
  logic          fclk, fclk_q;
  logic [FW-1:0] fcnt;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          ext_flag, rel_flag;
  logic          clk_s, dat_s;
  logic          fall, tmo;
  logic          frame_done, frame_good;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];
  assign fall  = fclk_q & ~fclk;
  // A fall in the same cycle as expiry restarts the count instead of aborting.
  assign tmo   = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT - 1));

  assign key.busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      fclk     <= 1'b1;
      fclk_q   <= 1'b1;
      fcnt     <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      fclk_q   <= fclk;
      if (clk_s == fclk) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        fclk <= clk_s;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    frame_good = 1'b0;
    if (tmo) begin
      state_next = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!dat_s) state_next = DATA;
        DATA:    if (bit_idx == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP: begin
          state_next = IDLE;
          frame_done = 1'b1;
          frame_good = dat_s && (^{shreg, par_bit});
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bit_idx <= '0;
      par_bit <= 1'b0;
      tcnt    <= '0;
    end else begin
      if (fall || tmo || state == IDLE) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
      if (fall) begin
        case (state)
          IDLE:   bit_idx <= '0;
          DATA: begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
          PARITY: par_bit <= dat_s;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key.key_valid   <= 1'b0;
      key.key_code    <= '0;
      key.key_ext     <= 1'b0;
      key.key_release <= 1'b0;
      key.frame_err   <= 1'b0;
      ext_flag        <= 1'b0;
      rel_flag        <= 1'b0;
    end else begin
      key.key_valid <= 1'b0;
      key.frame_err <= 1'b0;
      if (frame_done && frame_good) begin
        if (shreg == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (shreg == 8'hF0) begin
          rel_flag <= 1'b1;
        end else begin
          key.key_valid   <= 1'b1;
          key.key_code    <= shreg;
          key.key_ext     <= ext_flag;
          key.key_release <= rel_flag;
          ext_flag        <= 1'b0;
          rel_flag        <= 1'b0;
        end
      end else if (frame_done || tmo) begin
        key.frame_err <= 1'b1;
        ext_flag      <= 1'b0;
        rel_flag      <= 1'b0;
      end
    end
  end

endmodule
